// File: rtl/nsc8_mem_pkg.sv
// nsc8_mem_pkg: shared definitions for the NSC8 memory access path.
//   - state_t    : transaction sequencer states (IDLE -> ACCESS -> RESP).
//   - PORT_CPU   : requester index of the CPU control path.
//   - PORT_LD    : requester index of the program loader/debug port.
package nsc8_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LD  = 1'b1;

endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: combinational two-way round-robin picker.
//   req0, req1   : pending requests.
//   last_grant   : index of the most recently granted port.
//   lock1        : (ARB_LOCK_EN only) keeps granting port 1 while it owns
//                  the last grant and is still requesting.
//   grant_valid  : at least one request is pending.
//   grant_idx    : index of the winning port.
// Build option: define ARB_LOCK_EN to add the lock1 input.
module rr_arbiter_2
    import nsc8_mem_pkg::*;
(
`ifdef ARB_LOCK_EN
    input  logic lock1,
`endif
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_idx
);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block can leave it unassigned and infer a latch.
        grant_valid = req0 | req1;
        grant_idx   = PORT_CPU;
        if (req0 && req1) begin
            // Tie: the port that did not win last time goes next.
            grant_idx = ~last_grant;
        end else if (req1) begin
            grant_idx = PORT_LD;
        end
`ifdef ARB_LOCK_EN
        // Loader burst: port 1 keeps the bus while it holds the last grant.
        if (lock1 && (last_grant == PORT_LD) && req1) begin
            grant_idx = PORT_LD;
        end
`endif
    end

endmodule

// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: shares a single-port RAM between the CPU (port 0) and
// the program loader/debug port (port 1). Each access runs IDLE -> ACCESS ->
// RESP; RAM strobes and acks are decoded from state only.
//   clk, reset_n               : clock, asynchronous active-low reset.
//   reqX/weX/addrX/wdataX      : request, write enable, address, write data.
//   ackX                       : one-cycle completion pulse.
//   rdata                      : last read data, valid with the read's ack.
//   ram_address/ram_data_in    : latched address/data driven to the RAM.
//   ram_store/ram_oe           : RAM write strobe / output enable (ACCESS).
//   ram_data_out               : RAM output bus, sampled at the end of ACCESS.
// Build option: define ARB_LOCK_EN to add the lock1 input (loader bursts).
module ram_access_arbiter
    import nsc8_mem_pkg::*;
#(
    parameter int N      = 8,
    parameter int ADDR_W = N / 2
) (
    input  logic              clk,
    input  logic              reset_n,
`ifdef ARB_LOCK_EN
    input  logic              lock1,
`endif
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [N-1:0]      wdata0,
    output logic              ack0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [N-1:0]      wdata1,
    output logic              ack1,
    output logic [N-1:0]      rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic [N-1:0]      ram_data_in,
    output logic              ram_store,
    output logic              ram_oe,
    input  logic [N-1:0]      ram_data_out
);

    state_t state, state_nxt;
    logic   last_grant;
    logic   lat_port;
    logic   lat_we;
    logic   grant_valid;
    logic   grant_idx;

    rr_arbiter_2 u_arb (
`ifdef ARB_LOCK_EN
        .lock1       (lock1),
`endif
        .req0        (req0),
        .req1        (req1),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of process order.
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (grant_valid) state_nxt = ST_ACCESS;
            ST_ACCESS: state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from state and latched fields only, so requester
    // inputs never reach the RAM strobes combinationally.
    always_comb begin
        ram_store = 1'b0;
        ram_oe    = 1'b0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        case (state)
            ST_ACCESS: begin
                ram_store = lat_we;
                ram_oe    = ~lat_we;
            end
            ST_RESP: begin
                ack0 = (lat_port == PORT_CPU);
                ack1 = (lat_port == PORT_LD);
            end
            default: ;
        endcase
    end

    // Grant latch and read capture. Fields are frozen at grant so later
    // requester changes cannot disturb the access in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant  <= PORT_LD;     // port 0 wins the first tie
            lat_port    <= PORT_CPU;
            lat_we      <= 1'b0;
            ram_address <= '0;
            ram_data_in <= '0;
            rdata       <= '0;
        end else begin
            if (state == ST_IDLE && grant_valid) begin
                last_grant  <= grant_idx;
                lat_port    <= grant_idx;
                lat_we      <= grant_idx ? we1    : we0;
                ram_address <= grant_idx ? addr1  : addr0;
                ram_data_in <= grant_idx ? wdata1 : wdata0;
            end
            if (state == ST_ACCESS && !lat_we) begin
                rdata <= ram_data_out;
            end
        end
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb_ram_access_arbiter: directed self-checking bench for ram_access_arbiter
// with a behavioural 16x8 RAM on the ram_* interface.
// Build option: define ARB_LOCK_EN to also exercise the lock1 input.
module tb_ram_access_arbiter;

    localparam int N      = 8;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              lock1 = 1'b0;
    logic              req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
    logic [N-1:0]      wdata0 = '0, wdata1 = '0;
    logic              ack0, ack1, ram_store, ram_oe;
    logic [N-1:0]      rdata, ram_data_in;
    wire  [N-1:0]      ram_data_out;
    logic [ADDR_W-1:0] ram_address;

    logic [N-1:0] mem [16];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ram_access_arbiter #(.N(N), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
`ifdef ARB_LOCK_EN
        .lock1        (lock1),
`endif
        .req0         (req0),
        .we0          (we0),
        .addr0        (addr0),
        .wdata0       (wdata0),
        .ack0         (ack0),
        .req1         (req1),
        .we1          (we1),
        .addr1        (addr1),
        .wdata1       (wdata1),
        .ack1         (ack1),
        .rdata        (rdata),
        .ram_address  (ram_address),
        .ram_data_in  (ram_data_in),
        .ram_store    (ram_store),
        .ram_oe       (ram_oe),
        .ram_data_out (ram_data_out)
    );

    // Behavioural single-port RAM.
    always @(posedge clk) begin
        if (ram_store) mem[ram_address] <= ram_data_in;
    end
    assign ram_data_out = ram_oe ? mem[ram_address] : 8'hzz;

    // Neither pair of mutually exclusive outputs may ever be high together.
    always @(negedge clk) begin
        if (ram_store && ram_oe) begin
            n_checks++; n_fail++;
            $display("FAIL store_oe_overlap: got=both required=exclusive");
        end
        if (ack0 && ack1) begin
            n_checks++; n_fail++;
            $display("FAIL ack_overlap: got=both required=exclusive");
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h required=%0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One full transaction, entered and left at a negedge while IDLE.
    task automatic do_txn(input logic port, input logic we, input logic [3:0] addr,
                          input logic [7:0] wdata, input logic [7:0] exp_rdata);
        if (port) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata; end
        else      begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata; end
        @(negedge clk);                       // ACCESS
        check("acc_addr",  32'(ram_address), 32'(addr));
        check("acc_store", 32'(ram_store),   32'(we));
        check("acc_oe",    32'(ram_oe),      32'(!we));
        check("acc_ack",   32'({ack1, ack0}), 32'd0);
        if (we) check("acc_din", 32'(ram_data_in), 32'(wdata));
        @(negedge clk);                       // RESP
        check("resp_ack0",  32'(ack0), 32'(!port));
        check("resp_ack1",  32'(ack1), 32'(port));
        check("resp_strb",  32'({ram_store, ram_oe}), 32'd0);
        check("resp_rdata", 32'(rdata), 32'(exp_rdata));
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);                       // IDLE
        check("idle_ack", 32'({ack1, ack0}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        #1;
        check("rst_ack",   32'({ack1, ack0}), 32'd0);
        check("rst_strb",  32'({ram_store, ram_oe}), 32'd0);
        check("rst_addr",  32'(ram_address), 32'd0);
        check("rst_din",   32'(ram_data_in), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        apply_reset();

        // Write via loader, read back via CPU; preload the other words.
        do_txn(1'b1, 1'b1, 4'h3, 8'hA5, 8'h00);
        check("mem3", 32'(mem[3]), 32'hA5);
        do_txn(1'b0, 1'b0, 4'h3, 8'h00, 8'hA5);
        do_txn(1'b1, 1'b1, 4'hF, 8'h3C, 8'hA5);
        do_txn(1'b1, 1'b1, 4'h2, 8'h11, 8'hA5);
        do_txn(1'b1, 1'b1, 4'h1, 8'h42, 8'hA5);
        do_txn(1'b1, 1'b1, 4'h7, 8'h99, 8'hA5);

        // Both requesting after reset: grants 0,1,0,1, acks 3 cycles apart.
        apply_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'h3;
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'hF;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check("rr_ack0", 32'(ack0), 32'(k == 2 || k == 8));
            check("rr_ack1", 32'(ack1), 32'(k == 5 || k == 11));
            if (k == 2 || k == 8)  check("rr_rdata0", 32'(rdata), 32'hA5);
            if (k == 5 || k == 11) check("rr_rdata1", 32'(rdata), 32'h3C);
            if (k == 11) begin req0 = 1'b0; req1 = 1'b0; end
        end
        @(negedge clk);

        // Read of 0xF then a write: rdata holds through the write.
        do_txn(1'b0, 1'b0, 4'h3, 8'h00, 8'hA5);
        do_txn(1'b0, 1'b0, 4'hF, 8'h00, 8'h3C);
        do_txn(1'b1, 1'b1, 4'h5, 8'h77, 8'h3C);

        // Reset during ACCESS of a write: strobe drops, no ack, no write.
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'h2; wdata0 = 8'hEE;
        @(negedge clk);
        check("abort_store_pre", 32'(ram_store), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("abort_store", 32'(ram_store), 32'd0);
        check("abort_ack",   32'({ack1, ack0}), 32'd0);
        req0 = 1'b0; we0 = 1'b0;
        @(negedge clk);
        check("abort_ack2",  32'({ack1, ack0}), 32'd0);
        check("abort_mem2",  32'(mem[2]), 32'h11);
        reset_n = 1'b1;
        @(negedge clk);
        do_txn(1'b0, 1'b0, 4'h2, 8'h00, 8'h11);

        // Address change after grant is ignored.
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'h1;
        @(negedge clk);
        addr0 = 4'h7;
        check("latch_addr", 32'(ram_address), 32'h1);
        @(negedge clk);
        check("latch_ack",   32'(ack0), 32'd1);
        check("latch_rdata", 32'(rdata), 32'h42);
        req0 = 1'b0;
        @(negedge clk);

`ifdef ARB_LOCK_EN
        // Locked loader burst, then release hands the bus back to port 0.
        apply_reset();
        lock1 = 1'b1;
        do_txn(1'b1, 1'b0, 4'h7, 8'h00, 8'h99);
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'h1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'h7;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("lock_ack0", 32'(ack0), 32'(k == 8));
            check("lock_ack1", 32'(ack1), 32'(k == 2 || k == 5));
            if (k == 5) lock1 = 1'b0;
            if (k == 8) begin
                check("lock_rdata", 32'(rdata), 32'h42);
                req0 = 1'b0; req1 = 1'b0;
            end
        end
        @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
